// File: rtl/i2c_arb_pkg.sv
// ------------------------------------------------------------------
// i2c_arb_pkg : command layout and FSM encoding for i2c_bus_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package i2c_arb_pkg;

  localparam int CMD_W    = 12;
  localparam int START    = 11;
  localparam int STOP     = 10;
  localparam int RD       = 9;
  localparam int NACK_OUT = 8;

  localparam logic [CMD_W-1:0] CMD_STOP_ONLY = 12'h400;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ISSUE       = 3'd1,
    WAIT_RSP    = 3'd2,
    HOLD        = 3'd3,
    FORCE_ISSUE = 3'd4,
    FORCE_WAIT  = 3'd5
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// ------------------------------------------------------------------
// rr_pick : combinational round-robin search starting after 'last'
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from farthest to nearest so the nearest requester after 'last' wins.
  always_comb begin
    int cand;
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N; k >= 1; k--) begin
      cand = (int'(last) + k) % N;
      if (req[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2c_bus_arbiter.sv
// ------------------------------------------------------------------
// i2c_bus_arbiter : shares one I2C byte master among N_REQ requesters
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int TIMEOUT_CYC = 125000,
  localparam int OW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [CMD_W*N_REQ-1:0] req_cmd,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [7:0]             rsp_data,
  output logic                   rsp_nack,
  output logic                   m_cmd_valid,
  output logic [CMD_W-1:0]       m_cmd,
  input  logic                   m_cmd_ready,
  input  logic                   m_rsp_valid,
  input  logic [7:0]             m_rsp_data,
  input  logic                   m_rsp_nack,
  output logic [OW-1:0]          owner,
  output logic                   busy,
  output logic [N_REQ-1:0]       timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t       state, state_nxt;
  logic [CMD_W-1:0] cmd_r;
  logic [OW-1:0]    owner_r;
  logic [OW-1:0]    last_owner;
  logic             busy_r;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] start_req;
  logic             pick_found;
  logic [OW-1:0]    pick_idx;
  logic             grant;
  logic [OW-1:0]    grant_idx;

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_start
    assign start_req[g] = req_valid[g] & req_cmd[g*CMD_W + START];
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_rr_pick (
    .req   (start_req),
    .last  (last_owner),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner = owner_r;
  assign busy  = busy_r;

  always_comb begin
    state_nxt   = state;
    req_ready   = '0;
    grant       = 1'b0;
    grant_idx   = owner_r;
    m_cmd_valid = 1'b0;
    m_cmd       = '0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          req_ready = onehot(pick_idx);
          grant     = 1'b1;
          grant_idx = pick_idx;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        m_cmd_valid = 1'b1;
        m_cmd       = cmd_r;
        if (m_cmd_ready) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (m_rsp_valid) state_nxt = cmd_r[STOP] ? IDLE : HOLD;
      end
      HOLD: begin
        if (req_valid[owner_r]) begin
          req_ready = onehot(owner_r);
          grant     = 1'b1;
          state_nxt = ISSUE;
        end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
          state_nxt = FORCE_ISSUE;
        end
      end
      FORCE_ISSUE: begin
        m_cmd_valid = 1'b1;
        m_cmd       = CMD_STOP_ONLY;
        if (m_cmd_ready) state_nxt = FORCE_WAIT;
      end
      FORCE_WAIT: begin
        if (m_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A grant while reset is held would be lost, so suppress the handshake.
    if (reset) begin
      req_ready = '0;
      grant     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_r       <= '0;
      owner_r     <= '0;
      last_owner  <= OW'(N_REQ - 1);
      busy_r      <= 1'b0;
      cnt         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      rsp_nack    <= 1'b0;
      timeout_err <= '0;
    end else begin
      state       <= state_nxt;
      rsp_valid   <= '0;
      timeout_err <= '0;
      if (grant) begin
        cmd_r      <= req_cmd[int'(grant_idx)*CMD_W +: CMD_W];
        owner_r    <= grant_idx;
        last_owner <= grant_idx;
        busy_r     <= 1'b1;
      end
      if (state == HOLD && !grant) cnt <= cnt + CW'(1);
      else                         cnt <= '0;
      if (state == WAIT_RSP && m_rsp_valid) begin
        rsp_valid <= onehot(owner_r);
        rsp_data  <= m_rsp_data;
        rsp_nack  <= m_rsp_nack;
        if (cmd_r[STOP]) busy_r <= 1'b0;
      end
      // The forced stop's response is swallowed; only the eviction is reported.
      if (state == FORCE_WAIT && m_rsp_valid) begin
        timeout_err <= onehot(owner_r);
        busy_r      <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_bus_arbiter.sv
// ------------------------------------------------------------------
// tb_i2c_bus_arbiter : scoreboard bench with a behavioural byte master
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 16;

  typedef struct packed {
    logic [1:0] idx;
    logic       nack;
    logic [7:0] data;
  } rsp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [CMD_W*N-1:0] req_cmd;
  logic [N-1:0]     req_ready, rsp_valid, timeout_err;
  logic [7:0]       rsp_data;
  logic             rsp_nack;
  logic             m_cmd_valid;
  logic [CMD_W-1:0] m_cmd;
  logic             m_cmd_ready;
  logic             m_rsp_valid;
  logic [7:0]       m_rsp_data;
  logic             m_rsp_nack;
  logic [1:0]       owner;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int rsp_lat  = 2;

  int               exp_gnt[$];
  logic [CMD_W-1:0] exp_cmd[$];
  rsp_t             exp_rsp[$];
  int               exp_tmo[$];

  i2c_bus_arbiter #(
    .N_REQ       (N),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_cmd     (req_cmd),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_nack    (rsp_nack),
    .m_cmd_valid (m_cmd_valid),
    .m_cmd       (m_cmd),
    .m_cmd_ready (m_cmd_ready),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_data  (m_rsp_data),
    .m_rsp_nack  (m_rsp_nack),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] oh(input int i);
    oh    = '0;
    oh[i] = 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  task automatic exp_r(input int idx, input logic nack, input logic [7:0] d);
    rsp_t e;
    e.idx  = 2'(idx);
    e.nack = nack;
    e.data = d;
    exp_rsp.push_back(e);
  endtask

  task automatic issue(input int r, input logic [CMD_W-1:0] c);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_cmd[r*CMD_W +: CMD_W] = c;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
    end
    if (!got) fail_now($sformatf("grant_wait_r%0d", r));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid[r]) got = 1'b1;
    end
    if (!got) fail_now($sformatf("rsp_wait_r%0d", r));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Behavioural byte master: reads return the inverted data field, 0xEE writes NACK.
  initial begin
    int               cd;
    logic [CMD_W-1:0] lc;
    cd = 0;
    lc = '0;
    m_rsp_valid = 1'b0;
    m_rsp_data  = 8'h00;
    m_rsp_nack  = 1'b0;
    forever begin
      @(negedge clk);
      m_rsp_valid = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          m_rsp_valid = 1'b1;
          m_rsp_data  = lc[RD] ? ~lc[7:0] : 8'h00;
          m_rsp_nack  = (lc[7:0] == 8'hEE);
        end
      end
      if (m_cmd_valid && m_cmd_ready && !reset) begin
        cd = rsp_lat;
        lc = m_cmd;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    int   g;
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (req_ready != '0) begin
          if (exp_gnt.size() == 0) check("unexpected_grant", 32'(req_ready), 32'd0);
          else begin
            g = exp_gnt.pop_front();
            check("grant", 32'(req_ready), 32'(oh(g)));
          end
        end
        if (m_cmd_valid && m_cmd_ready) begin
          if (exp_cmd.size() == 0) check("unexpected_mcmd", 32'(m_cmd), 32'hFFFF_FFFF);
          else check("m_cmd", 32'(m_cmd), 32'(exp_cmd.pop_front()));
        end
        if (rsp_valid != '0) begin
          if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
          else begin
            e = exp_rsp.pop_front();
            check("rsp", {21'd0, rsp_valid, rsp_nack, rsp_data},
                  {21'd0, oh(int'(e.idx)), e.nack, e.data});
          end
        end
        if (timeout_err != '0) begin
          if (exp_tmo.size() == 0) check("unexpected_tmo", 32'(timeout_err), 32'd0);
          else begin
            g = exp_tmo.pop_front();
            check("timeout_err", 32'(timeout_err), 32'(oh(g)));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    reset       = 1'b1;
    req_valid   = '0;
    req_cmd     = '0;
    m_cmd_ready = 1'b1;

    // Requests during reset must not be granted.
    req_valid = 3'b111;
    req_cmd   = {12'h8C0, 12'h8B0, 12'h8A0};
    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_mcmd", {19'd0, m_cmd_valid, m_cmd}, 32'd0);
    check("reset_pulses", {26'd0, rsp_valid, timeout_err}, 32'd0);

    // Start-write then write-with-stop from requester 0.
    exp_gnt.push_back(0); exp_gnt.push_back(0);
    exp_cmd.push_back(12'h8A0); exp_cmd.push_back(12'h401);
    exp_r(0, 1'b0, 8'h00); exp_r(0, 1'b0, 8'h00);
    issue(0, 12'h8A0);
    wait_rsp(0);
    check("busy_in_hold", 32'(busy), 32'd1);
    issue(0, 12'h401);
    wait_rsp(0);
    check("busy_after_stop", 32'(busy), 32'd0);

    // Simultaneous start from 1 and 2: 1 wins, then 2 beats 1's re-request.
    do_reset();
    exp_gnt = '{1, 1, 2, 2, 1, 1};
    exp_cmd = '{12'h8B0, 12'h402, 12'h8C0, 12'h63C, 12'h8EE, 12'h403};
    exp_r(1, 1'b0, 8'h00); exp_r(1, 1'b0, 8'h00);
    exp_r(2, 1'b0, 8'h00); exp_r(2, 1'b0, 8'hC3);
    exp_r(1, 1'b1, 8'h00); exp_r(1, 1'b0, 8'h00);
    fork
      begin
        issue(1, 12'h8B0); wait_rsp(1); issue(1, 12'h402); wait_rsp(1);
        issue(1, 12'h8EE); wait_rsp(1); issue(1, 12'h403); wait_rsp(1);
      end
      begin
        issue(2, 12'h8C0); wait_rsp(2); issue(2, 12'h63C); wait_rsp(2);
      end
    join
    check("busy_after_s2", 32'(busy), 32'd0);

    // Requester 2 must wait while 0 holds the bus.
    exp_gnt = '{0, 0, 2, 2};
    exp_cmd = '{12'h8A2, 12'h402, 12'h8C2, 12'h404};
    exp_r(0, 1'b0, 8'h00); exp_r(0, 1'b0, 8'h00);
    exp_r(2, 1'b0, 8'h00); exp_r(2, 1'b0, 8'h00);
    fork
      begin
        issue(0, 12'h8A2); wait_rsp(0);
        repeat (5) @(posedge clk);
        check("owner_hold", 32'(owner), 32'd0);
        issue(0, 12'h402); wait_rsp(0);
      end
      begin
        repeat (3) @(posedge clk);
        issue(2, 12'h8C2); wait_rsp(2); issue(2, 12'h404); wait_rsp(2);
      end
    join

    // Silent owner gets evicted after TMO idle cycles.
    exp_gnt.push_back(0);
    exp_cmd.push_back(12'h8A4); exp_cmd.push_back(12'h400);
    exp_r(0, 1'b0, 8'h00);
    exp_tmo.push_back(0);
    issue(0, 12'h8A4);
    wait_rsp(0);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (m_cmd_valid) k = i;
    end
    check("timeout_latency", 32'(k), 32'(TMO));
    k = 0;
    for (int i = 0; i < 20 && k == 0; i++) begin
      @(negedge clk);
      if (timeout_err != '0) k = 1;
    end
    if (k == 0) fail_now("timeout_pulse_wait");
    check("busy_after_evict", 32'(busy), 32'd0);

    // Reset during WAIT_RSP abandons the transaction; the late response is ignored.
    rsp_lat = 5;
    exp_gnt.push_back(0);
    exp_cmd.push_back(12'h8A6);
    issue(0, 12'h8A6);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_mcmd", {19'd0, m_cmd_valid, m_cmd}, 32'd0);
    check("midreset_pulses", {26'd0, rsp_valid, timeout_err}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) cnt++;
    end
    check("late_rsp_ignored", 32'(cnt), 32'd0);
    rsp_lat = 2;

    // Master stalls 5 cycles: command held stable, owner re-request not accepted.
    m_cmd_ready = 1'b0;
    exp_gnt = '{0, 0};
    exp_cmd = '{12'h8A7, 12'h401};
    exp_r(0, 1'b0, 8'h00); exp_r(0, 1'b0, 8'h00);
    issue(0, 12'h8A7);
    req_valid[0] = 1'b1;
    req_cmd[0 +: CMD_W] = 12'h401;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_mcmd", {19'd0, m_cmd_valid, m_cmd}, {19'd0, 1'b1, 12'h8A7});
      check("stall_no_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    m_cmd_ready  = 1'b1;
    wait_rsp(0);
    issue(0, 12'h401);
    wait_rsp(0);
    check("busy_after_stall", 32'(busy), 32'd0);

    repeat (5) @(negedge clk);
    check("left_grants", 32'(exp_gnt.size()), 32'd0);
    check("left_cmds", 32'(exp_cmd.size()), 32'd0);
    check("left_rsps", 32'(exp_rsp.size()), 32'd0);
    check("left_tmos", 32'(exp_tmo.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
